// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and the
// odd-parity helper used by both bus directions.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a registered falling-edge
// strobe; shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
    fall_d = prev_q & ~sync_q;
  end

  // Lines idle high, so the history resets high to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked
// bits and ACK check. Both bus lines are open-drain (oe=1 pulls low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic clk_sync, clk_fall;
  logic data_sync, data_fall;
  logic unused_data_fall;

  ps2_tx_state_t    state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic             busy_q, busy_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic [TO_W-1:0]  to_cnt_inc;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall)
  );

  assign unused_data_fall = data_fall;

  assign to_cnt_inc = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_oe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d   = tx_data;
          parity_d  = odd_parity(tx_data);
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q >= INH_LAST) begin
          state_d   = REQ;
          data_oe_d = 1'b1;
        end else if (inh_cnt_q != INH_MAX) begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      REQ: begin
        to_cnt_d  = '0;
        data_oe_d = 1'b1;
        state_d   = XFER;
      end
      XFER: begin
        to_cnt_d  = to_cnt_inc;
        data_oe_d = data_oe_q;
        // Start bit stays driven until the first device fall; each fall then
        // presents the next bit for the device to sample on its rising edge.
        if (clk_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_d = ~shift_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
            end
          end
        end
      end
      ACK: begin
        to_cnt_d = to_cnt_inc;
        state_d  = data_sync ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        to_cnt_d = to_cnt_inc;
        if (clk_sync && data_sync) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q inside {XFER, ACK, WAIT_IDLE}) && (to_cnt_d == TO_LIMIT)) begin
      state_d   = ERR;
      data_oe_d = 1'b0;
    end

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    clk_oe_d   = (state_d == INHIBIT) || (state_d == REQ);
    tx_done_d  = (state_d == DONE);
    tx_err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the opposite direction of the keyboard receiver path. It takes one byte from the CPU-side I/O logic and serialises it onto the PS/2 bus using the standard host-request sequence: inhibit, request-to-send, 11 device-clocked bits, and the device ACK. Typical payloads are keyboard commands such as LED set (0xED) and reset (0xFF). Both PS/2 lines are open-drain: the block only ever drives them low or releases them.

## Interface

Parameters:
- INHIBIT_CYCLES, default 5000: clock-low inhibit time in clk cycles (≥100 µs at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum clk cycles from clock release to ACK completion (15 ms at 50 MHz).

Ports:
- clk, in, 1: single system clock; all logic on posedge.
- reset, in, 1: synchronous, active-low reset.
- tx_valid, in, 1: byte request.
- tx_data, in, 8: byte to send.
- tx_ready, out, 1: block idle; request accepted when tx_valid & tx_ready.
- tx_done, out, 1: one-cycle pulse on successful ACK.
- tx_err, out, 1: one-cycle pulse on NACK or timeout.
- busy, out, 1: transfer in progress; the receiver ignores the bus while this is high.
- ps2_clk_in, in, 1: raw PS/2 clock line, asynchronous.
- ps2_data_in, in, 1: raw PS/2 data line, asynchronous.
- ps2_clk_oe, out, 1: 1 pulls PS2_CLK low.
- ps2_data_oe, out, 1: 1 pulls PS2_DATA low.

## Operation

**Input conditioning**
- Both raw lines pass through a 2-FF synchroniser.
- Falling edge of PS/2 clock: fall = sync_prev & ~sync.

**States**
- IDLE: tx_ready=1. On accept, latch tx_data into shift_reg, compute parity = ~^tx_data (odd parity), go to INHIBIT.
- INHIBIT: clk_oe=1. Count INHIBIT_CYCLES, then go to REQ.
- REQ: clk_oe=1, data_oe=1 for exactly one cycle. This drives the start bit 0.
- XFER: clk_oe=0. Timeout counter starts. On each fall, advance bit_cnt (0..10):
  - falls 1–8: data_oe = ~shift_reg[bit_cnt-1], LSB first.
  - fall 9: data_oe = ~parity.
  - fall 10: data_oe = 0 (stop bit released).
  - fall 11: go to ACK.
- ACK: sample data_sync in the cycle fall 11 is seen.
  - 0 → WAIT_IDLE.
  - 1 → ERR.
- WAIT_IDLE: wait until clk_sync & data_sync are both 1, then go to DONE.
- DONE: pulse tx_done, return to IDLE.
- ERR: release both lines, pulse tx_err, return to IDLE.

**Rules**
- Timeout: if the counter reaches TIMEOUT_CYCLES in XFER, ACK or WAIT_IDLE, go to ERR.
- busy = (state ≠ IDLE).
- tx_valid outside IDLE is ignored. No queueing.
- tx_data is sampled only at accept.

## Timing

- Reset (reset=0, sampled at posedge):
  - state IDLE; all counters 0.
  - ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0.
  - tx_ready is forced 0 while reset=0 and becomes 1 in the first cycle after release.
- Reset mid-transfer: lines are released in the next cycle. No tx_done or tx_err is emitted.
- Accept at cycle N:
  - clk_oe=1 from N+1.
  - REQ occupies cycle N+1+INHIBIT_CYCLES.
  - clk_oe falls to 0 one cycle later.
- Edge-detect latency: 2 sync stages + 1 edge register. data_oe updates 3 cycles after the physical falling edge, well inside the ≈30 µs PS/2 clock-low phase.
- tx_done and tx_err are mutually exclusive and each high for exactly one cycle. tx_ready returns in the following cycle.
- Back-to-back: a new accept is possible the cycle after DONE/ERR. INHIBIT is always repeated.
- Counters: inhibit counter $clog2(INHIBIT_CYCLES+1) bits, timeout counter $clog2(TIMEOUT_CYCLES+1) bits, bit_cnt 4 bits. All saturate; none wrap.

## Structure

- Shared package ps2_pkg holds:
  - ps2_tx_state_t enum {IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, DONE, ERR};
  - function odd_parity(logic [7:0]);
  - PS2_FRAME_BITS = 11.
- Sub-module ps2_line_sync: 2-FF synchroniser plus falling-edge detector, instantiated once per line. The keyboard receiver reuses it.

## Test plan

- Send 0xED, device model ACKs:
  - bits sampled on PS/2 rising edges are 0, 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - tx_done pulses once; tx_err stays 0.
- Send 0x07: parity bit 0; tx_done. Send 0xFF: parity bit 1; tx_done.
- Device model leaves data high at bit 11: tx_err pulses; both oe return to 0; tx_ready=1 next cycle.
- Device never clocks: tx_err exactly TIMEOUT_CYCLES cycles after REQ+1. INHIBIT with TIMEOUT_CYCLES=1000 checks the exact count.
- reset=0 during bit 4: the next cycle shows oe=0, busy=0, no done/err pulse. A new 0xF4 send after release completes.
- tx_valid held high through a transfer: exactly one frame is sent per accept. A second frame starts only after DONE, and is preceded by a full INHIBIT_CYCLES low period.
